// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and encoder command kinds.
// The encoder and the main control decoder both import this package.
package mips_isa_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_AND  = 4'd2,
        K_OR   = 4'd3,
        K_SLT  = 4'd4,
        K_ADDI = 4'd5,
        K_LW   = 4'd6,
        K_SW   = 4'd7,
        K_BEQ  = 4'd8,
        K_J    = 4'd9,
        K_JAL  = 4'd10
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SLOT = 2'd2
    } enc_state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OP_R, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: command kind plus register/immediate/target fields
// into one 32-bit MIPS word, with legality and control-transfer flags.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal,
    output logic        is_ctrl_xfer
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        word         = NOP_WORD;
        legal        = 1'b1;
        is_ctrl_xfer = 1'b0;
        case (kind)
            K_ADD:  word = r_word(rs, rt, rd, FN_ADD);
            K_SUB:  word = r_word(rs, rt, rd, FN_SUB);
            K_AND:  word = r_word(rs, rt, rd, FN_AND);
            K_OR:   word = r_word(rs, rt, rd, FN_OR);
            K_SLT:  word = r_word(rs, rt, rd, FN_SLT);
            K_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
            K_LW:   word = i_word(OP_LW, rs, rt, imm);
            K_SW:   word = i_word(OP_SW, rs, rt, imm);
            K_BEQ: begin
                word         = i_word(OP_BEQ, rs, rt, imm);
                is_ctrl_xfer = 1'b1;
            end
            K_J: begin
                word         = j_word(OP_J, target);
                is_ctrl_xfer = 1'b1;
            end
            K_JAL: begin
                word         = j_word(OP_JAL, target);
                is_ctrl_xfer = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder: writes encoded commands into consecutive
// instruction-memory words, with optional NOP delay slot after branches/jumps.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit DELAY_SLOT = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    enc_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              full;
    logic              slot_last;

    logic [31:0] pk_word;
    logic        pk_legal;
    logic        pk_ctrl;

    logic        accept;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        wr_ok;
    logic        ovf_hit;
    logic        ill_hit;
    logic        finish;
    logic        session_start;

    mips_instr_pack u_pack (
        .kind         (cmd_kind),
        .rs           (cmd_rs),
        .rt           (cmd_rt),
        .rd           (cmd_rd),
        .imm          (cmd_imm),
        .target       (cmd_target),
        .word         (pk_word),
        .legal        (pk_legal),
        .is_ctrl_xfer (pk_ctrl)
    );

    assign cmd_ready = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // A write attempted while full is the overflow condition; it never reaches memory.
    assign wr_ok   = wr_req & ~full;
    assign ovf_hit = wr_req & full;

    always_comb begin
        state_nxt     = state;
        wr_req        = 1'b0;
        wr_data       = pk_word;
        ill_hit       = 1'b0;
        finish        = 1'b0;
        session_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt     = ST_RUN;
                    session_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!pk_legal) begin
                        ill_hit = 1'b1;
                        if (cmd_last) begin
                            state_nxt = ST_IDLE;
                            finish    = 1'b1;
                        end
                    end else begin
                        wr_req = 1'b1;
                        if (full) begin
                            state_nxt = ST_IDLE;
                            finish    = 1'b1;
                        end else if (DELAY_SLOT && pk_ctrl) begin
                            state_nxt = ST_SLOT;
                        end else if (cmd_last) begin
                            state_nxt = ST_IDLE;
                            finish    = 1'b1;
                        end
                    end
                end
            end
            ST_SLOT: begin
                wr_req  = 1'b1;
                wr_data = NOP_WORD;
                if (full || slot_last) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr         <= '0;
            full         <= 1'b0;
            slot_last    <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we <= wr_ok;
            done    <= finish;
            if (session_start) begin
                addr         <= base_addr;
                full         <= 1'b0;
                word_count   <= '0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (wr_ok) begin
                imem_addr  <= addr;
                imem_wdata <= wr_data;
                word_count <= word_count + (ADDR_W+1)'(1);
                // The last address marks the memory full instead of wrapping.
                if (addr == ADDR_MAX) full <= 1'b1;
                else                  addr <= addr + ADDR_W'(1);
            end
            if (ill_hit) err_illegal  <= 1'b1;
            if (ovf_hit) err_overflow <= 1'b1;
            if (accept)  slot_last    <= cmd_last;
        end
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader. It turns symbolic instruction commands into 32-bit MIPS words: the opcode/funct encoding that the main control decoder consumes. It writes those words into consecutive instruction-memory locations. It sits between the testbench/boot loader and the instruction memory write port. It optionally inserts a NOP delay slot after every branch or jump.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- DELAY_SLOT, 1, 1 = emit 32'h0000_0000 after every BEQ/J/JAL; 0 = none

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a load session (sampled only in IDLE)
- base_addr  in  ADDR_W  first word address of the session
- cmd_valid  in  1  command present
- cmd_ready  out  1  encoder accepts command this cycle
- cmd_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 J, 10 JAL, 11-15 illegal
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_imm  in  16  I-type immediate/offset
- cmd_target  in  26  J-type target
- cmd_last  in  1  final command of session
- imem_we  out  1  write strobe, one word per cycle
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- err_illegal  out  1  sticky, illegal cmd_kind seen
- err_overflow  out  1  sticky, write past address 2^ADDR_W-1 attempted
- word_count  out  ADDR_W+1  words written this session (NOPs included)

## Operation
- Encoding:
  - R-type: {6'd0, rs, rt, rd, 5'd0, funct}, with funct ADD 32, SUB 34, AND 36, OR 37, SLT 42.
  - I-type: {op, rs, rt, imm}, with op ADDI 8, LW 35, SW 43, BEQ 4.
  - J-type: {op, target}, with op J 2, JAL 3.
- FSM states:
  - IDLE: start=1 goes to RUN. The same edge loads addr=base_addr, clears word_count, clears err_illegal and err_overflow, and clears the full flag.
  - RUN: cmd_ready=1. On accept (cmd_valid & cmd_ready), the encoded word is registered to the imem outputs.
    - If DELAY_SLOT=1 and the kind is BEQ/J/JAL, go to SLOT.
    - Else if cmd_last, go to IDLE.
    - Else stay in RUN.
  - SLOT: cmd_ready=0. Emit one NOP write. Then go to IDLE if the pending command was last, else back to RUN.
- Address handling:
  - Each write increments addr and word_count.
  - A write at address all-ones sets the internal full flag. addr never wraps.
- Illegal kind:
  - The handshake still completes; there is no write and no address advance.
  - err_illegal is set.
  - If cmd_last, return to IDLE with a done pulse.
- Overflow: any write attempted while full is suppressed. It sets err_overflow, aborts to IDLE and pulses done. Any pending slot is dropped.
- start while busy is ignored. cmd_valid in IDLE is ignored (cmd_ready=0).

## Timing
- Reset values: state IDLE, every output 0, addr 0, full flag 0.
- Latency: a command accepted at edge N appears as imem_we/addr/wdata during cycle N+1. The delay-slot NOP follows in cycle N+2.
- Throughput: one command per cycle in RUN. Branches and jumps cost two cycles when DELAY_SLOT=1.
- cmd_ready first rises in the cycle after start is sampled.
- done is asserted in the same cycle as the session's final imem_we. For an illegal last command or an overflow abort, it is asserted in the cycle after the accept.
- Sticky errors hold until the next accepted start or reset.
- rst mid-session: immediate return to IDLE and all outputs 0. A partially written session is not completed.

## Structure
- Package mips_isa_pkg holds:
  - opcode constants (R 0, J 2, JAL 3, BEQ 4, ADDI 8, LW 35, SW 43);
  - funct constants;
  - the cmd_kind enumeration;
  - the NOP constant.
  The control decoder should share it.
- Sub-module mips_instr_pack is purely combinational. It maps kind and fields to a 32-bit word plus legal and is_ctrl_xfer flags. The top holds the FSM, address counter, output registers and error flags.

## Test plan
- start, base 8'h10, then ADD rs=1 rt=2 rd=3 with last → one write at 10 with data 32'h0022_1820; done in the same cycle; word_count=1.
- DELAY_SLOT=1, start base 0, then BEQ rs=1 rt=2 imm=16'h0004 followed by LW rs=0 rt=5 imm=8 last → writes 0:32'h1022_0004, 1:32'h0000_0000, 2:32'h8C05_0008; cmd_ready low during the slot cycle.
- JAL target 26'h000_0040 last, DELAY_SLOT=0 → one write 32'h0C00_0040; done in the same cycle.
- kind 12 followed by ADDI rs=0 rt=4 imm=16'hFFFF last → err_illegal=1; single write 32'h2004_FFFF at base; word_count=1.
- ADDR_W=8, base 8'hFE, then three SW commands → writes at FE and FF; the third write is suppressed; err_overflow=1; done pulses; word_count=2.
- Assert rst while in SLOT → next cycle imem_we=0, busy=0, errors 0; a new start works normally.
